// File: rtl/store_merge_buffer.sv
// ============================================================================
// Module   : store_merge_buffer
// Purpose  : Single-line write-combining buffer; merges byte-enabled word
//            stores into one line and drains it over a valid/ready port.
//            Optional idle auto-drain enabled by macro STORE_MERGE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_merge_buffer #(
  parameter int WORD_W         = 32,
  parameter int LINE_W         = 256,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [ADDR_W-1:0]      st_addr,
  input  logic [WORD_W-1:0]      st_wdata,
  input  logic [WORD_W/8-1:0]    st_byte_en,
  input  logic                   flush_req,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [ADDR_W-1:0]      wb_addr,
  output logic [LINE_W-1:0]      wb_data,
  output logic [LINE_W/8-1:0]    wb_mask,
  output logic                   empty
);

  localparam int WB     = WORD_W / 8;
  localparam int LB     = LINE_W / 8;
  localparam int OFF_W  = $clog2(LB);
  localparam int BOFF_W = $clog2(WB);
  localparam int NW     = LINE_W / WORD_W;
  localparam int TAG_W  = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic [TAG_W-1:0]  r_tag;
  logic [LINE_W-1:0] r_data;
  logic [LB-1:0]     r_mask;

  logic [TAG_W-1:0]  w_st_tag;
  logic [OFF_W-1:0]  w_off;
  logic [OFF_W-1:0]  w_slot;
  logic              w_tag_hit;
  logic              w_accept;
  logic              w_full;
  logic              w_timeout;
  logic              w_fill_exit;
  logic [LINE_W-1:0] w_mrg_data;
  logic [LB-1:0]     w_mrg_mask;

  generate
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
    end
  endgenerate

  assign w_st_tag  = st_addr[ADDR_W-1:OFF_W];
  assign w_off     = st_addr[OFF_W-1:0];
  assign w_slot    = w_off >> BOFF_W;
  assign w_tag_hit = (w_st_tag == r_tag);

  always_comb begin
    st_ready = 1'b0;
    case (r_state)
      S_EMPTY: st_ready = 1'b1;
      S_FILL:  st_ready = w_tag_hit;
      default: st_ready = 1'b0;
    endcase
  end

  assign w_accept = st_valid && st_ready;

  // Merge the incoming word over the held line image; EMPTY always holds zeros.
  always_comb begin
    w_mrg_data = r_data;
    w_mrg_mask = r_mask;
    for (int w = 0; w < NW; w++) begin
      if (w_slot == OFF_W'(w)) begin
        for (int i = 0; i < WB; i++) begin
          if (st_byte_en[i]) begin
            w_mrg_data[(w*WB+i)*8 +: 8] = st_wdata[i*8 +: 8];
            w_mrg_mask[w*WB+i]          = 1'b1;
          end
        end
      end
    end
  end

  assign w_full = &w_mrg_mask;

`ifdef STORE_MERGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_cnt;

  assign w_timeout = (r_state == S_FILL) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || (r_state != S_FILL) || w_accept || w_fill_exit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // A mismatching store leaves FILL without being accepted; it is retried from EMPTY.
  assign w_fill_exit = (r_state == S_FILL) &&
                       ((st_valid && !w_tag_hit) || flush_req || w_timeout ||
                        (w_accept && w_full));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_tag   <= '0;
      r_data  <= '0;
      r_mask  <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept && (|st_byte_en)) begin
            r_tag   <= w_st_tag;
            r_data  <= w_mrg_data;
            r_mask  <= w_mrg_mask;
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_accept) begin
            r_data <= w_mrg_data;
            r_mask <= w_mrg_mask;
          end
          if (w_fill_exit) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (wb_ready) begin
            r_data  <= '0;
            r_mask  <= '0;
            r_state <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign wb_valid = (r_state == S_DRAIN);
  assign empty    = (r_state == S_EMPTY);
  assign wb_addr  = {r_tag, {OFF_W{1'b0}}};
  assign wb_data  = r_data;
  assign wb_mask  = r_mask;

endmodule

`default_nettype wire

// File: tb/tb_store_merge_buffer.sv
// ============================================================================
// Module   : tb_store_merge_buffer
// Purpose  : Self-checking bench for store_merge_buffer: directed scenarios
//            plus a randomized run against a byte-level line model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_merge_buffer;

  localparam int WORD_W = 32;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam int TMO    = 16;
  localparam int LB     = LINE_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [WORD_W-1:0] st_wdata;
  logic [3:0]        st_byte_en;
  logic              flush_req;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [LINE_W-1:0] wb_data;
  logic [LB-1:0]     wb_mask;
  logic              empty;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  store_merge_buffer #(
    .WORD_W(WORD_W), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_wdata(st_wdata), .st_byte_en(st_byte_en), .flush_req(flush_req),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_mask(wb_mask), .empty(empty)
  );

  // Inputs change at the falling edge; outputs are read 1 time unit later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_byte_en = '0;
    flush_req = 1'b0; wb_ready = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid = 1'b1; st_addr = a; st_wdata = d; st_byte_en = be;
    tick();
    st_valid = 1'b0; st_byte_en = '0;
  endtask

  task automatic flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  task automatic drain();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    total++; if (empty !== 1'b1)    begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL reset_st_ready got=%b exp=1", st_ready); end
    total++; if (wb_mask !== '0)    begin bad++; $display("FAIL reset_wb_mask got=%h exp=0", wb_mask); end
    total++; if (wb_addr !== '0)    begin bad++; $display("FAIL reset_wb_addr got=%h exp=0", wb_addr); end
    total++; if (wb_data !== '0)    begin bad++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
  endtask

  task automatic test_full_line();
    for (int k = 0; k < 8; k++) begin
      #1;
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL full_early_valid k=%0d got=%b exp=0", k, wb_valid); end
      store(32'h100 + 32'(k*4), 32'h1111_1111 * 32'(k), 4'hF);
    end
    #1;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%b exp=1", wb_valid); end
    total++; if (wb_addr !== 32'h100) begin bad++; $display("FAIL full_addr got=%h exp=100", wb_addr); end
    total++; if (wb_mask !== 32'hFFFF_FFFF) begin bad++; $display("FAIL full_mask got=%h exp=ffffffff", wb_mask); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (wb_data[k*32 +: 32] !== 32'h1111_1111 * 32'(k)) begin
        bad++; $display("FAIL full_word%0d got=%h exp=%h", k, wb_data[k*32 +: 32], 32'h1111_1111 * 32'(k));
      end
    end
    drain();
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_empty_after got=%b exp=1", empty); end
  endtask

  task automatic test_partial_flush();
    logic [LINE_W-1:0] exp_d;
    exp_d = '0;
    exp_d[4*8 +: 8] = 8'hDD;
    exp_d[6*8 +: 8] = 8'hBB;
    store(32'h204, 32'hAABB_CCDD, 4'b0101);
    #1;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL pf_early_valid got=%b exp=0", wb_valid); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL pf_empty_fill got=%b exp=0", empty); end
    flush();
    #1;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL pf_valid got=%b exp=1", wb_valid); end
    total++; if (wb_addr !== 32'h200) begin bad++; $display("FAIL pf_addr got=%h exp=200", wb_addr); end
    total++; if (wb_mask !== 32'h0000_0050) begin bad++; $display("FAIL pf_mask got=%h exp=00000050", wb_mask); end
    total++; if (wb_data !== exp_d) begin bad++; $display("FAIL pf_data got=%h exp=%h", wb_data, exp_d); end
    drain();
  endtask

  task automatic test_conflict();
    store(32'h300, 32'hCAFE_F00D, 4'hF);
    st_valid = 1'b1; st_addr = 32'h420; st_wdata = 32'h5555_AAAA; st_byte_en = 4'hF;
    #1;
    total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL cf_ready_fill got=%b exp=0", st_ready); end
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL cf_ready_drain c=%0d got=%b exp=0", c, st_ready); end
      total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL cf_valid c=%0d got=%b exp=1", c, wb_valid); end
      total++; if (wb_addr !== 32'h300) begin bad++; $display("FAIL cf_addr c=%0d got=%h exp=300", c, wb_addr); end
      total++; if (wb_mask !== 32'h0000_000F) begin bad++; $display("FAIL cf_mask c=%0d got=%h exp=f", c, wb_mask); end
      total++; if (wb_data !== LINE_W'(32'hCAFE_F00D)) begin bad++; $display("FAIL cf_data c=%0d got=%h", c, wb_data); end
      tick();
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    #1;
    total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL cf_ready_empty got=%b exp=1", st_ready); end
    tick();
    st_valid = 1'b0; st_byte_en = '0;
    #1;
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL cf_new_fill got=%b exp=0", empty); end
    flush();
    #1;
    total++; if (wb_addr !== 32'h420) begin bad++; $display("FAIL cf_new_addr got=%h exp=420", wb_addr); end
    total++; if (wb_data[31:0] !== 32'h5555_AAAA) begin bad++; $display("FAIL cf_new_data got=%h exp=5555aaaa", wb_data[31:0]); end
    drain();
  endtask

  task automatic test_overwrite();
    store(32'h500, 32'h1234_5678, 4'hF);
    store(32'h500, 32'h0000_00EE, 4'b0001);
    flush();
    #1;
    total++; if (wb_data[31:0] !== 32'h1234_56EE) begin bad++; $display("FAIL ow_word0 got=%h exp=123456ee", wb_data[31:0]); end
    total++; if (wb_mask !== 32'h0000_000F) begin bad++; $display("FAIL ow_mask got=%h exp=f", wb_mask); end
    drain();
  endtask

  task automatic test_reset_mid_drain();
    store(32'h640, 32'hDEAD_BEEF, 4'hF);
    flush();
    #1;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL rd_pre_valid got=%b exp=1", wb_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rd_valid got=%b exp=0", wb_valid); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rd_empty got=%b exp=1", empty); end
    total++; if (wb_mask !== '0) begin bad++; $display("FAIL rd_mask got=%h exp=0", wb_mask); end
    total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL rd_ready got=%b exp=1", st_ready); end
  endtask

  task automatic test_timeout();
    int seen;
    seen = 0;
    store(32'h700, 32'h0BAD_CAFE, 4'hF);
    for (int n = 1; n <= 100 && seen == 0; n++) begin
      tick();
      #1;
      if (wb_valid === 1'b1) seen = n;
    end
`ifdef STORE_MERGE_TIMEOUT_EN
    total++; if (seen != TMO) begin bad++; $display("FAIL timeout_cycles got=%0d exp=%0d", seen, TMO); end
`else
    total++; if (seen != 0) begin bad++; $display("FAIL no_timeout got_valid_at=%0d exp=0", seen); end
    flush();
`endif
    #1;
    total++; if (wb_addr !== 32'h700) begin bad++; $display("FAIL timeout_addr got=%h exp=700", wb_addr); end
    drain();
  endtask

  // Reference line: byte image, per-byte valid, tag and whether a line is held.
  logic [7:0]  m_bytes [LB];
  logic [LB-1:0] m_mask;
  logic [26:0] m_tag;
  bit          m_open;

  function automatic logic [LINE_W-1:0] model_line();
    logic [LINE_W-1:0] v;
    v = '0;
    for (int b = 0; b < LB; b++) if (m_mask[b]) v[b*8 +: 8] = m_bytes[b];
    return v;
  endfunction

  task automatic test_random();
    bit pend, expect_drain, acc, fire, flush_eff;
    int slot;
    pend = 0; expect_drain = 0; m_open = 0; m_mask = '0; m_tag = '0;
    for (int b = 0; b < LB; b++) m_bytes[b] = 8'h00;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!pend) begin
        st_valid = ($urandom_range(0, 9) < 7);
        st_addr = {5'b0, 27'h40 + 27'($urandom_range(0, 1)), 5'b0} |
                  32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 3));
        st_wdata = $urandom;
        st_byte_en = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      flush_req = ($urandom_range(0, 19) == 0);
      wb_ready  = ($urandom_range(0, 9) < 6);
      #1;
      acc  = st_valid && st_ready;
      fire = wb_valid && wb_ready;
      total++; if (empty !== !m_open) begin bad++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%b", cyc, empty, !m_open); end
      if (expect_drain) begin
        total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL rnd_drain_late cyc=%0d got=%b exp=1", cyc, wb_valid); end
        expect_drain = 0;
      end
      if (st_valid && m_open && (st_addr[31:5] != m_tag)) begin
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL rnd_mismatch_ready cyc=%0d got=%b exp=0", cyc, st_ready); end
      end
      flush_eff = flush_req && m_open && !wb_valid;
      if (fire) begin
        total++; if (wb_addr !== {m_tag, 5'b0}) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, wb_addr, {m_tag, 5'b0}); end
        total++; if (wb_mask !== m_mask) begin bad++; $display("FAIL rnd_mask cyc=%0d got=%h exp=%h", cyc, wb_mask, m_mask); end
        total++; if (wb_data !== model_line()) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, wb_data, model_line()); end
        m_open = 0; m_mask = '0;
      end
      if (acc && (st_byte_en != 4'h0 || m_open)) begin
        if (!m_open) begin
          m_open = 1; m_tag = st_addr[31:5]; flush_eff = 0;
        end
        slot = int'(st_addr[4:2]);
        for (int i = 0; i < 4; i++) if (st_byte_en[i]) begin
          m_bytes[slot*4+i] = st_wdata[i*8 +: 8];
          m_mask[slot*4+i]  = 1'b1;
        end
        if (&m_mask) expect_drain = 1;
      end
      if (flush_eff) expect_drain = 1;
      tick();
      pend = st_valid && !acc;
    end
    idle_inputs();
    if (m_open) begin
      flush();
      drain();
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_line();
    test_partial_flush();
    test_conflict();
    test_overwrite();
    test_reset_mid_drain();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
